// File: rtl/ahbl_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO block: register offsets, HTRANS
// encodings and the byte-lane mask helper used by the write path.
package ahbl_gpio_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [4:0] OFF_DATA_IN  = 5'h00;
  localparam logic [4:0] OFF_DATA_OUT = 5'h04;
  localparam logic [4:0] OFF_OE       = 5'h08;
  localparam logic [4:0] OFF_IM       = 5'h0C;
  localparam logic [4:0] OFF_RIS      = 5'h10;
  localparam logic [4:0] OFF_IC       = 5'h14;

  // Sizes above word collapse to a full-word write.
  function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << lo;
      3'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/ahbl_gpio_sync_edge.sv
// Two-flop pad synchronizer plus rising-edge detector for the GPIO inputs.
// The edge flop only exists when AHBL_GPIO_IRQ_EN is defined.
module gpio_sync_edge
  import ahbl_gpio_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= gpio_in;
      sync <= meta;
    end
  end

  assign sync_out = sync;

`ifdef AHBL_GPIO_IRQ_EN
  logic [WIDTH-1:0] prev;

  // Cleared by reset, so pins held high through reset register as an edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) prev <= '0;
    else        prev <= sync;
  end

  assign rise = sync & ~prev;
`else
  assign rise = '0;
`endif

endmodule

// File: rtl/ahbl_gpio.sv
// AHB-Lite GPIO slave, zero wait states. Define AHBL_GPIO_IRQ_EN to build the
// interrupt mask/status/clear registers and the IRQ output.
module ahbl_gpio
  import ahbl_gpio_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic             IRQ
);

  logic             ap_valid;
  logic             ap_write;
  logic [2:0]       ap_word;
  logic [2:0]       ap_size;
  logic [1:0]       ap_lo;
  logic             addr_hit;
  logic             wr_en;
  logic [4:0]       offset;
  logic [31:0]      wmask;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] oe;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] im;
  logic [WIDTH-1:0] ris;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign addr_hit = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_word  <= '0;
      ap_size  <= '0;
      ap_lo    <= '0;
    end else if (HREADY) begin
      ap_valid <= addr_hit;
      if (addr_hit) begin
        ap_write <= HWRITE;
        ap_word  <= HADDR[4:2];
        ap_size  <= HSIZE;
        ap_lo    <= HADDR[1:0];
      end
    end
  end

  assign wr_en  = ap_valid & ap_write & HREADY;
  assign offset = {ap_word, 2'b00};
  assign wmask  = lane_mask(ap_size, ap_lo);

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old);
    return (old & ~wmask[WIDTH-1:0]) | (HWDATA[WIDTH-1:0] & wmask[WIDTH-1:0]);
  endfunction

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_out <= '0;
      oe       <= '0;
    end else if (wr_en) begin
      if (offset == OFF_DATA_OUT) data_out <= merge(data_out);
      if (offset == OFF_OE)       oe       <= merge(oe);
    end
  end

  gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .gpio_in  (GPIO_IN),
    .sync_out (sync_in),
    .rise     (rise)
  );

`ifdef AHBL_GPIO_IRQ_EN
  logic [WIDTH-1:0] ic_clr;
  logic             irq_q;

  assign ic_clr = (wr_en && offset == OFF_IC) ? (HWDATA[WIDTH-1:0] & wmask[WIDTH-1:0]) : '0;

  // Set is OR-ed in after the clear so a same-cycle edge survives the clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      im    <= '0;
      ris   <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && offset == OFF_IM) im <= merge(im);
      ris   <= (ris & ~ic_clr) | rise;
      irq_q <= |(ris & im);
    end
  end

  assign IRQ = irq_q;
`else
  assign im  = '0;
  assign ris = '0;
  assign IRQ = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_DATA_IN:  rd_word[WIDTH-1:0] = sync_in;
      OFF_DATA_OUT: rd_word[WIDTH-1:0] = data_out;
      OFF_OE:       rd_word[WIDTH-1:0] = oe;
      OFF_IM:       rd_word[WIDTH-1:0] = im;
      OFF_RIS:      rd_word[WIDTH-1:0] = ris;
      default:      rd_word = '0;
    endcase
  end

  assign HRDATA    = (ap_valid & ~ap_write) ? rd_word : 32'h0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIO_OUT  = data_out;
  assign GPIO_OE   = oe;

  assign unused_bits = ^{HADDR[31:5], HWDATA, wmask, rise};

endmodule
